// File: rtl/shift_counter_gen_if.sv
// Control/status bundle for shift_counter_gen: step controls, parallel load and registered outputs.
interface shift_counter_gen_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             err;

  modport master (
    output en, mode, dir, load, load_val,
    input  out, wrap, err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output out, wrap, err
  );
endinterface

// File: rtl/shift_counter_gen.sv
// Ring / Johnson shift counter stepping on the falling clock edge, with wrap pulse.
// Illegal-state correction is compiled in when SHIFTCNT_SELFCORR_EN is defined.
module shift_counter_gen #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  shift_counter_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] S_VAL = WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic [WIDTH-1:0] w_out_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_step;
  logic             w_fb;

  // Feedback bit leaves the end we shift away from; Johnson inverts it.
  always_comb begin
    w_fb   = 1'b0;
    w_step = r_out;
    if (bus.dir) begin
      w_fb   = r_out[WIDTH-1] ^ bus.mode;
      w_step = {r_out[WIDTH-2:0], w_fb};
    end else begin
      w_fb   = r_out[0] ^ bus.mode;
      w_step = {w_fb, r_out[WIDTH-1:1]};
    end
  end

`ifdef SHIFTCNT_SELFCORR_EN
  logic             r_err;
  logic             w_err_next;
  logic             w_legal;
  logic [WIDTH-2:0] w_edges;

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edges
    assign w_edges[gi] = r_out[gi] ^ r_out[gi+1];
  end

  // Johnson states have at most one 0/1 boundary along the register.
  assign w_legal = bus.mode ? $onehot0(w_edges) : $onehot(r_out);

  always_comb begin
    w_out_next  = r_out;
    w_wrap_next = 1'b0;
    w_err_next  = 1'b0;
    if (bus.load) begin
      w_out_next = bus.load_val;
    end else if (bus.en && !w_legal) begin
      w_out_next = S_VAL;
      w_err_next = 1'b1;
    end else if (bus.en) begin
      w_out_next  = w_step;
      w_wrap_next = (w_step == S_VAL);
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_next;
    end
  end

  assign bus.err = r_err;
`else
  always_comb begin
    w_out_next  = r_out;
    w_wrap_next = 1'b0;
    if (bus.load) begin
      w_out_next = bus.load_val;
    end else if (bus.en) begin
      w_out_next  = w_step;
      w_wrap_next = (w_step == S_VAL);
    end
  end

  assign bus.err = 1'b0;
`endif

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_out  <= S_VAL;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_out_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.out  = r_out;
  assign bus.wrap = r_wrap;
endmodule
